// File: rtl/delay_line_pkg.sv
// Shared types and sizing for the delay-line measurement sequencer.
package delay_line_pkg;

    localparam int unsigned DL_TAPS     = 32;
    localparam int unsigned DL_NAVG_MAX = 7;
    localparam int unsigned DL_CW       = $clog2(DL_TAPS + 1);
    localparam int unsigned DL_SUM_W    = DL_CW + DL_NAVG_MAX;
    localparam int unsigned DL_NAVG_W   = 3;

    typedef enum logic [2:0] {
        StIdle,
        StLaunch,
        StSettle,
        StCapture,
        StAccum,
        StRecover,
        StDone
    } state_e;

    function automatic logic [DL_NAVG_W-1:0] clamp_navg(input logic [DL_NAVG_W-1:0] n,
                                                        input int unsigned max_n);
        if (int'(n) > int'(max_n)) begin
            return DL_NAVG_W'(max_n);
        end
        return n;
    endfunction

endpackage

// File: rtl/delay_line_meas_ctrl_if.sv
// Result handshake between the measurement sequencer and its consumer.
interface delay_line_meas_ctrl_if #(
    parameter int unsigned CW = delay_line_pkg::DL_CW
);
    logic          res_valid;
    logic          res_ready;
    logic [CW-1:0] res_data;

    modport master (output res_valid, output res_data, input res_ready);
    modport slave  (input res_valid, input res_data, output res_ready);
endinterface

// File: rtl/delay_line_therm_enc.sv
// Thermometer decoder: tap count plus a flag for codes whose ones are not contiguous from bit 0.
module delay_line_therm_enc
    import delay_line_pkg::*;
#(
    parameter int unsigned NTAPS = DL_TAPS,
    parameter int unsigned CW    = $clog2(NTAPS + 1)
) (
    input  logic [NTAPS-1:0] taps_i,
    output logic [CW-1:0]    count_o,
    output logic             bubble_o
);

    always_comb begin
        count_o  = '0;
        bubble_o = 1'b0;
        for (int i = 0; i < int'(NTAPS); i++) begin
            count_o = count_o + CW'(taps_i[i]);
        end
        // A set tap above a clear one can only come from a bubble.
        for (int i = 1; i < int'(NTAPS); i++) begin
            if (taps_i[i] && !taps_i[i-1]) begin
                bubble_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/delay_line_meas_ctrl.sv
// Launch/settle/capture sequencer that averages 2^navg delay-line samples into one tap count.
module delay_line_meas_ctrl
    import delay_line_pkg::*;
#(
    parameter int unsigned TAPS     = DL_TAPS,
    parameter int unsigned SETTLE   = 2,
    parameter int unsigned NAVG_MAX = DL_NAVG_MAX
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_i,
    input  logic                   abort_i,
    input  logic [DL_NAVG_W-1:0]   navg_i,
    output logic                   launch_o,
    output logic                   capture_o,
    input  logic [TAPS-1:0]        taps_i,
    output logic                   busy_o,
    output logic                   err_o,
    delay_line_meas_ctrl_if.master res
);

    localparam int unsigned CW    = $clog2(TAPS + 1);
    localparam int unsigned SUM_W = CW + NAVG_MAX;
    localparam int unsigned CNT_W = NAVG_MAX + 1;
    localparam int unsigned SET_W = $clog2(SETTLE + 1);
    localparam logic [SET_W-1:0] SettleLast = SET_W'(SETTLE - 1);

    state_e               state_q, state_d;
    logic [SUM_W-1:0]     sum_q, sum_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [SET_W-1:0]     set_q, set_d;
    logic [DL_NAVG_W-1:0] navg_q, navg_d;
    logic                 launch_q, launch_d;
    logic                 capture_q, capture_d;
    logic                 busy_q, busy_d;
    logic                 valid_q, valid_d;
    logic                 err_q, err_d;
    logic [CW-1:0]        data_q, data_d;
    logic [CW-1:0]        tap_count;
    logic                 tap_bubble;
    logic                 active;

    delay_line_therm_enc #(
        .NTAPS (TAPS),
        .CW    (CW)
    ) u_therm_enc (
        .taps_i   (taps_i),
        .count_o  (tap_count),
        .bubble_o (tap_bubble)
    );

    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        set_d   = set_q;
        navg_d  = navg_q;
        err_d   = err_q;
        active  = state_q inside {StLaunch, StSettle, StCapture, StAccum, StRecover};

        // Abort takes priority over every transition out of the measuring states.
        if (active && abort_i) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start_i) begin
                        state_d = StLaunch;
                        navg_d  = clamp_navg(navg_i, NAVG_MAX);
                        sum_d   = '0;
                        cnt_d   = '0;
                        err_d   = 1'b0;
                    end
                end
                StLaunch: begin
                    state_d = StSettle;
                    set_d   = SettleLast;
                end
                StSettle: begin
                    if (set_q == '0) state_d = StCapture;
                    else             set_d   = set_q - 1'b1;
                end
                StCapture: state_d = StAccum;
                StAccum: begin
                    sum_d   = sum_q + SUM_W'(tap_count);
                    err_d   = err_q | tap_bubble;
                    cnt_d   = cnt_q + 1'b1;
                    set_d   = SettleLast;
                    state_d = StRecover;
                end
                StRecover: begin
                    if (set_q != '0) begin
                        set_d = set_q - 1'b1;
                    end else if (cnt_q == (CNT_W'(1) << navg_q)) begin
                        state_d = StDone;
                    end else begin
                        state_d = StLaunch;
                    end
                end
                StDone: begin
                    if (res.res_ready) state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end

        // Outputs are registered from the next state so none has a path from the inputs.
        launch_d  = state_d inside {StLaunch, StSettle, StCapture, StAccum};
        capture_d = (state_d == StCapture);
        busy_d    = !(state_d inside {StIdle, StDone});
        valid_d   = (state_d == StDone);
        data_d    = valid_d ? CW'(sum_q >> navg_q) : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            sum_q     <= '0;
            cnt_q     <= '0;
            set_q     <= '0;
            navg_q    <= '0;
            launch_q  <= 1'b0;
            capture_q <= 1'b0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            sum_q     <= sum_d;
            cnt_q     <= cnt_d;
            set_q     <= set_d;
            navg_q    <= navg_d;
            launch_q  <= launch_d;
            capture_q <= capture_d;
            busy_q    <= busy_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            data_q    <= data_d;
        end
    end

    assign launch_o      = launch_q;
    assign capture_o     = capture_q;
    assign busy_o        = busy_q;
    assign err_o         = err_q;
    assign res.res_valid = valid_q;
    assign res.res_data  = data_q;

endmodule

// File: tb/tb_delay_line_meas_ctrl.sv
// Bench for delay_line_meas_ctrl: cycle-index reference model plus directed and random stimulus.
module tb_delay_line_meas_ctrl;
    import delay_line_pkg::*;

    localparam int unsigned TAPS     = 32;
    localparam int unsigned SETTLE   = 2;
    localparam int unsigned NAVG_MAX = 7;
    localparam int unsigned CW       = 6;
    localparam int          PER      = 2 * SETTLE + 3;

    logic            clk = 1'b0;
    logic            rst;
    logic            start_i;
    logic            abort_i;
    logic [2:0]      navg_i;
    logic            launch_o;
    logic            capture_o;
    logic [TAPS-1:0] taps_i;
    logic            busy_o;
    logic            err_o;

    delay_line_meas_ctrl_if #(.CW(CW)) res_if ();

    delay_line_meas_ctrl #(
        .TAPS     (TAPS),
        .SETTLE   (SETTLE),
        .NAVG_MAX (NAVG_MAX)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start_i),
        .abort_i   (abort_i),
        .navg_i    (navg_i),
        .launch_o  (launch_o),
        .capture_o (capture_o),
        .taps_i    (taps_i),
        .busy_o    (busy_o),
        .err_o     (err_o),
        .res       (res_if)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cap_cnt = 0;
    int tap_mode = 0;
    logic [31:0] tap_const = '0;
    logic [31:0] tap_tab [4];

    // Reference model: a measurement is just a cycle index k since the start edge.
    bit m_active = 0;
    bit m_done   = 0;
    bit m_err    = 0;
    int m_k      = 0;
    int m_n      = 1;
    int m_navg   = 0;
    int m_sum    = 0;

    function automatic bit is_bubble(input logic [31:0] t);
        logic [63:0] therm;
        therm = (64'd1 << $countones(t)) - 64'd1;
        return t != therm[31:0];
    endfunction

    function automatic logic [31:0] rand_taps();
        logic [63:0] w;
        if ($urandom_range(0, 1) == 0) begin
            w = (64'd1 << $urandom_range(0, 32)) - 64'd1;
            return w[31:0];
        end
        return $urandom;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active <= 0;
            m_done   <= 0;
            m_err    <= 0;
            m_sum    <= 0;
            m_k      <= 0;
        end else if (m_active) begin
            if (abort_i) begin
                m_active <= 0;
            end else begin
                if ((m_k - 1) % PER == SETTLE + 2) begin
                    m_sum <= m_sum + $countones(taps_i);
                    if (is_bubble(taps_i)) m_err <= 1;
                end
                if (m_k == PER * m_n) begin
                    m_active <= 0;
                    m_done   <= 1;
                end
                m_k <= m_k + 1;
            end
        end else if (m_done) begin
            if (res_if.res_ready) m_done <= 0;
        end else if (start_i) begin
            m_active <= 1;
            m_k      <= 1;
            m_navg   <= (int'(navg_i) > NAVG_MAX) ? NAVG_MAX : int'(navg_i);
            m_n      <= 1 << ((int'(navg_i) > NAVG_MAX) ? NAVG_MAX : int'(navg_i));
            m_sum    <= 0;
            m_err    <= 0;
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    // One cycle: compare every output with the model, then drive the next taps value.
    task automatic step();
        int p;
        @(negedge clk);
        if (!rst) begin
            p = (m_k - 1) % PER;
            check("launch",  launch_o,  64'(m_active && p < SETTLE + 3));
            check("capture", capture_o, 64'(m_active && p == SETTLE + 1));
            check("busy",    busy_o,    64'(m_active));
            check("valid",   res_if.res_valid, 64'(m_done));
            check("err",     err_o,     64'(m_err));
            if (m_done) check("data", res_if.res_data, 64'((m_sum >> m_navg) % (1 << CW)));
        end
        if (capture_o) cap_cnt++;
        case (tap_mode)
            1:       taps_i = rand_taps();
            2:       taps_i = m_active ? tap_tab[((m_k - 1) / PER) % 4] : '0;
            default: taps_i = tap_const;
        endcase
    endtask

    task automatic wait_valid(inout int cyc);
        while (cyc < 2000 && !res_if.res_valid) begin
            step();
            start_i = 1'b0;
            cyc++;
        end
    endtask

    task automatic run_meas(input logic [2:0] n, output int cyc, output int caps);
        int c0;
        start_i = 1'b1;
        navg_i  = n;
        c0      = cap_cnt;
        cyc     = 0;
        wait_valid(cyc);
        caps = cap_cnt - c0;
    endtask

    task automatic handshake();
        res_if.res_ready = 1'b1;
        step();
        res_if.res_ready = 1'b0;
    endtask

    initial begin
        int  cyc;
        int  caps;
        bit  seen;
        rst = 1'b1;
        start_i = 1'b0;
        abort_i = 1'b0;
        navg_i  = '0;
        taps_i  = '0;
        res_if.res_ready = 1'b0;
        step();
        step();
        check("rst_launch", launch_o, 0);
        check("rst_busy",   busy_o, 0);
        check("rst_valid",  res_if.res_valid, 0);
        check("rst_data",   res_if.res_data, 0);
        check("rst_err",    err_o, 0);
        rst = 1'b0;
        step();

        // Single sample of 8 taps.
        tap_const = 32'h0000_00FF;
        run_meas(3'd0, cyc, caps);
        check("t1_cycle", cyc, 8);
        check("t1_caps",  caps, 1);
        check("t1_data",  res_if.res_data, 8);
        check("t1_err",   err_o, 0);
        handshake();

        // Four different samples averaged: (4+8+12+16)/4.
        tap_tab[0] = 32'h0000_000F;
        tap_tab[1] = 32'h0000_00FF;
        tap_tab[2] = 32'h0000_0FFF;
        tap_tab[3] = 32'h0000_FFFF;
        tap_mode = 2;
        run_meas(3'd2, cyc, caps);
        check("t2_cycle", cyc, 29);
        check("t2_caps",  caps, 4);
        check("t2_data",  res_if.res_data, 10);
        handshake();

        // Bubble sets err; next accepted start clears it one cycle later.
        tap_mode = 0;
        tap_const = 32'h0000_00F7;
        run_meas(3'd0, cyc, caps);
        check("t3_data", res_if.res_data, 7);
        check("t3_err",  err_o, 1);
        handshake();
        tap_const = 32'h0000_00FF;
        start_i = 1'b1;
        navg_i  = 3'd0;
        step();
        start_i = 1'b0;
        check("t3_err_clr", err_o, 0);
        cyc = 1;
        wait_valid(cyc);
        handshake();

        // Back-pressure: result held, start ignored, including on the handshake cycle.
        tap_const = 32'h0000_0003;
        run_meas(3'd1, cyc, caps);
        for (int i = 0; i < 10; i++) begin
            start_i = (i % 2 == 0);
            step();
            check("t4_hold_valid", res_if.res_valid, 1);
            check("t4_hold_data",  res_if.res_data, 2);
        end
        start_i = 1'b1;
        res_if.res_ready = 1'b1;
        step();
        start_i = 1'b0;
        res_if.res_ready = 1'b0;
        check("t4_idle_busy",  busy_o, 0);
        check("t4_idle_valid", res_if.res_valid, 0);
        run_meas(3'd0, cyc, caps);
        check("t4_restart_cycle", cyc, 8);
        check("t4_restart_data",  res_if.res_data, 2);
        handshake();

        // Abort in SETTLE of the second sample.
        start_i = 1'b1;
        navg_i  = 3'd2;
        step();
        start_i = 1'b0;
        repeat (8) step();
        check("t5_pre_launch", launch_o, 1);
        abort_i = 1'b1;
        step();
        abort_i = 1'b0;
        check("t5_launch", launch_o, 0);
        check("t5_busy",   busy_o, 0);
        seen = 0;
        repeat (40) begin
            step();
            if (res_if.res_valid) seen = 1;
        end
        check("t5_no_result", seen, 0);

        // Asynchronous reset while in CAPTURE.
        start_i = 1'b1;
        navg_i  = 3'd0;
        step();
        start_i = 1'b0;
        repeat (3) step();
        check("t6_capture", capture_o, 1);
        #1 rst = 1'b1;
        #1;
        check("t6_launch",  launch_o, 0);
        check("t6_capture_low", capture_o, 0);
        check("t6_busy",    busy_o, 0);
        check("t6_valid",   res_if.res_valid, 0);
        step();
        rst = 1'b0;
        step();

        // Full-scale accumulation over 128 samples.
        tap_const = 32'hFFFF_FFFF;
        run_meas(3'd7, cyc, caps);
        check("t7_cycle", cyc, 897);
        check("t7_data",  res_if.res_data, 32);
        check("t7_err",   err_o, 0);
        handshake();

        // Random traffic against the model.
        tap_mode = 1;
        for (int i = 0; i < 4000; i++) begin
            start_i = ($urandom_range(0, 7) == 0);
            abort_i = ($urandom_range(0, 63) == 0);
            navg_i  = 3'($urandom_range(0, 3));
            res_if.res_ready = ($urandom_range(0, 2) == 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
